rom_rd_arbiter: RTL and testbench

Two-port round-robin read arbiter that shares one single-port ROM IP instance (256 x 8, registered address and output) between two independent requesters, e.g. a key-driven address controller and a display/readout engine. It serialises requests onto the ROM port, tracks each in-flight read through the ROM's fixed read latency, and returns the data with a valid strobe to the port that issued the request. It sits between the requester logic and the ROM IP core in the IP-core example designs.

---
 rtl/rom_rd_arbiter.sv | 120 ++++++++++++
 tb/tb_rom_rd_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_arbiter.sv
// rom_rd_arbiter: two-port round-robin read arbiter sharing one single-port ROM.
// Requests are serialised onto the ROM port. A {valid, port} tag follows each
// read through the ROM latency, so the returned data is steered to the port
// that issued the read.
module rom_rd_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_rden,
  input  logic [DATA_W-1:0] i_rom_q
);

  // One tag stage per cycle from the grant through to the cycle the ROM data is valid
  localparam int unsigned TAG_W = RD_LAT + 1;

  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_last;       // 1: port 1 holds the most recent grant
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_rden;
  logic [TAG_W-1:0]  r_tag_vld;
  logic [TAG_W-1:0]  r_tag_port;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_eff0;
  logic w_eff1;
  logic w_win0;
  logic w_win1;
  logic w_any;
  logic w_tag_out;
  logic w_tag_port;

  // A port is masked in its own grant cycle, so it cannot win twice in a row
  assign w_eff0 = i_req0 & ~r_gnt0;
  assign w_eff1 = i_req1 & ~r_gnt1;

  // Round robin: on contention the port that did not win last time goes first
  assign w_win0 = w_eff0 & (~w_eff1 | r_last);
  assign w_win1 = w_eff1 & ~w_win0;
  assign w_any  = w_win0 | w_win1;

  assign w_tag_out  = r_tag_vld[TAG_W-1];
  assign w_tag_port = r_tag_port[TAG_W-1];

  // Grant pulses, last-grant pointer and ROM command registers
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_last     <= 1'b1;
      r_rom_addr <= '0;
      r_rom_rden <= 1'b0;
    end else begin
      r_gnt0     <= w_win0;
      r_gnt1     <= w_win1;
      r_rom_rden <= w_any;
      if (w_any) begin
        r_rom_addr <= w_win0 ? i_addr0 : i_addr1;
        r_last     <= w_win1;
      end
    end
  end

  // Tag shift register tracking each issued read through the ROM latency
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_tag_vld  <= '0;
      r_tag_port <= '0;
    end else begin
      r_tag_vld  <= {r_tag_vld[TAG_W-2:0], w_any};
      r_tag_port <= {r_tag_port[TAG_W-2:0], w_win1};
    end
  end

  // Capture ROM data for the owning port as its tag leaves the pipeline
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_tag_out & ~w_tag_port;
      r_rvalid1 <= w_tag_out & w_tag_port;
      if (w_tag_out & ~w_tag_port) begin
        r_rdata0 <= i_rom_q;
      end
      if (w_tag_out & w_tag_port) begin
        r_rdata1 <= i_rom_q;
      end
    end
  end

  assign o_gnt0     = r_gnt0;
  assign o_gnt1     = r_gnt1;
  assign o_rom_addr = r_rom_addr;
  assign o_rom_rden = r_rom_rden;
  assign o_rvalid0  = r_rvalid0;
  assign o_rvalid1  = r_rvalid1;
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb_rom_rd_arbiter: three arbiters (RD_LAT = 2, 1, 4) driven by shared
// requesters, each with its own ROM model returning ~addr.
module tb_rom_rd_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] addr0, addr1;

  int checks = 0;
  int errors = 0;

  // Per-instance DUT signals (a: RD_LAT=2, b: RD_LAT=1, c: RD_LAT=4)
  logic       gnt0_a, gnt1_a, rv0_a, rv1_a, rden_a;
  logic       gnt0_b, gnt1_b, rv0_b, rv1_b, rden_b;
  logic       gnt0_c, gnt1_c, rv0_c, rv1_c, rden_c;
  logic [7:0] rd0_a, rd1_a, raddr_a, rq_a;
  logic [7:0] rd0_b, rd1_b, raddr_b, rq_b;
  logic [7:0] rd0_c, rd1_c, raddr_c, rq_c;

  logic [2:0]      d_gnt0, d_gnt1, d_rv0, d_rv1, d_rden;
  logic [2:0][7:0] d_rd0, d_rd1, d_raddr;

  assign d_gnt0  = {gnt0_c, gnt0_b, gnt0_a};
  assign d_gnt1  = {gnt1_c, gnt1_b, gnt1_a};
  assign d_rv0   = {rv0_c, rv0_b, rv0_a};
  assign d_rv1   = {rv1_c, rv1_b, rv1_a};
  assign d_rden  = {rden_c, rden_b, rden_a};
  assign d_rd0   = {rd0_c, rd0_b, rd0_a};
  assign d_rd1   = {rd1_c, rd1_b, rd1_a};
  assign d_raddr = {raddr_c, raddr_b, raddr_a};

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  rom_rd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_dut_lat2 (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0_a), .o_rvalid0(rv0_a), .o_rdata0(rd0_a),
    .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1_a), .o_rvalid1(rv1_a), .o_rdata1(rd1_a),
    .o_rom_addr(raddr_a), .o_rom_rden(rden_a), .i_rom_q(rq_a));

  rom_rd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_lat1 (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0_b), .o_rvalid0(rv0_b), .o_rdata0(rd0_b),
    .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1_b), .o_rvalid1(rv1_b), .o_rdata1(rd1_b),
    .o_rom_addr(raddr_b), .o_rom_rden(rden_b), .i_rom_q(rq_b));

  rom_rd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(4)) u_dut_lat4 (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0_c), .o_rvalid0(rv0_c), .o_rdata0(rd0_c),
    .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1_c), .o_rvalid1(rv1_c), .o_rdata1(rd1_c),
    .o_rom_addr(raddr_c), .o_rom_rden(rden_c), .i_rom_q(rq_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: data = ~addr after RD_LAT cycles; junk when no read was issued
  logic [2:0][3:0][7:0] rch;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rch[i][3:1] <= rch[i][2:0];
      rch[i][0]   <= d_rden[i] ? ~d_raddr[i] : 8'($urandom);
    end
  end
  assign rq_a = rch[0][1];
  assign rq_b = rch[1][0];
  assign rq_c = rch[2][3];

  // Reference model: arbitration rules plus a per-instance response schedule
  int              cyc = 0;
  bit              m_gnt0 = 1'b0, m_gnt1 = 1'b0, m_rden = 1'b0, m_last = 1'b1;
  logic [7:0]      m_addr = 8'h00;
  bit   [2:0]      m_rv0 = '0, m_rv1 = '0;
  logic [2:0][7:0] m_rd0 = '0, m_rd1 = '0;
  bit              sv [3][8];
  bit              sp [3][8];
  logic [7:0]      sd [3][8];

  always @(posedge clk) begin : ref_model
    bit e0, e1, g0, g1;
    int slot;
    cyc = cyc + 1;
    if (rst) begin
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_rden = 1'b0; m_addr = 8'h00; m_last = 1'b1;
      m_rv0 = '0; m_rv1 = '0; m_rd0 = '0; m_rd1 = '0;
      for (int i = 0; i < 3; i++)
        for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        slot = cyc % 8;
        m_rv0[i] = 1'b0;
        m_rv1[i] = 1'b0;
        if (sv[i][slot]) begin
          if (sp[i][slot]) begin m_rv1[i] = 1'b1; m_rd1[i] = sd[i][slot]; end
          else             begin m_rv0[i] = 1'b1; m_rd0[i] = sd[i][slot]; end
          sv[i][slot] = 1'b0;
        end
      end
      e0 = req0 && !m_gnt0;
      e1 = req1 && !m_gnt1;
      g0 = e0 && (!e1 || m_last);
      g1 = e1 && !g0;
      m_gnt0 = g0;
      m_gnt1 = g1;
      m_rden = g0 || g1;
      if (g0 || g1) begin
        m_addr = g0 ? addr0 : addr1;
        m_last = g1;
        for (int i = 0; i < 3; i++) begin
          slot = (cyc + lat_of(i) + 1) % 8;
          sv[i][slot] = 1'b1;
          sp[i][slot] = g1;
          sd[i][slot] = ~m_addr;
        end
      end
    end
  end

  // Requesters: hold req/addr until granted, then present the next queued address
  logic [7:0] q0[$], q1[$];
  bit         allow_drop = 1'b0;

  always @(negedge clk) begin : requesters
    bit drop0, drop1;
    drop0 = 1'b0;
    drop1 = 1'b0;
    if (m_gnt0 && q0.size() > 0) void'(q0.pop_front());
    else if (allow_drop && req0 && q0.size() > 0 && $urandom_range(7) == 0) begin
      void'(q0.pop_front()); drop0 = 1'b1;
    end
    if (m_gnt1 && q1.size() > 0) void'(q1.pop_front());
    else if (allow_drop && req1 && q1.size() > 0 && $urandom_range(7) == 0) begin
      void'(q1.pop_front()); drop1 = 1'b1;
    end
    req0 = (q0.size() > 0) && !drop0;
    req1 = (q1.size() > 0) && !drop1;
    if (q0.size() > 0) addr0 = q0[0];
    if (q1.size() > 0) addr1 = q1[0];
  end

  task automatic idle(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q0.push_back(8'h5A);
    q1.push_back(8'hA5);
    repeat (4) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({d_gnt0[i], d_gnt1[i], d_rv0[i], d_rv1[i], d_rden[i]} !== 5'b0 ||
            d_rd0[i] !== 8'h00 || d_rd1[i] !== 8'h00 || d_raddr[i] !== 8'h00) begin
          errors++;
          $display("FAIL reset_outputs lat%0d: gnt=%b%b rv=%b%b rden=%b rd0=%h rd1=%h raddr=%h, required all zero",
                   lat_of(i), d_gnt0[i], d_gnt1[i], d_rv0[i], d_rv1[i], d_rden[i], d_rd0[i], d_rd1[i], d_raddr[i]);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_gnt0[i] !== 1'b1 || d_gnt1[i] !== 1'b0 || d_rden[i] !== 1'b1 || d_raddr[i] !== 8'h5A) begin
        errors++;
        $display("FAIL reset_first_grant lat%0d: gnt0=%b gnt1=%b rden=%b raddr=%h, required 1 0 1 5a",
                 lat_of(i), d_gnt0[i], d_gnt1[i], d_rden[i], d_raddr[i]);
      end
    end
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_gnt0[i] !== 1'b0 || d_gnt1[i] !== 1'b1 || d_raddr[i] !== 8'hA5) begin
        errors++;
        $display("FAIL reset_second_grant lat%0d: gnt0=%b gnt1=%b raddr=%h, required 0 1 a5",
                 lat_of(i), d_gnt0[i], d_gnt1[i], d_raddr[i]);
      end
    end
  endtask

  task automatic test_single_read();
    int  c0 = -1;
    bit  exp_rv;
    q0.push_back(8'h05);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); #1;
      if (c0 < 0 && req0) c0 = cyc;
      for (int i = 0; i < 3; i++) begin
        if (c0 >= 0 && cyc == c0 + 1) begin
          checks++;
          if (d_gnt0[i] !== 1'b1 || d_rden[i] !== 1'b1 || d_raddr[i] !== 8'h05) begin
            errors++;
            $display("FAIL single_grant lat%0d: gnt0=%b rden=%b raddr=%h, required 1 1 05",
                     lat_of(i), d_gnt0[i], d_rden[i], d_raddr[i]);
          end
        end
        exp_rv = (c0 >= 0) && (cyc == c0 + lat_of(i) + 2);
        checks++;
        if (d_rv0[i] !== exp_rv || d_rv1[i] !== 1'b0) begin
          errors++;
          $display("FAIL single_rvalid lat%0d cyc+%0d: rvalid0=%b rvalid1=%b, required %b 0",
                   lat_of(i), cyc - c0, d_rv0[i], d_rv1[i], exp_rv);
        end
        if (exp_rv) begin
          checks++;
          if (d_rd0[i] !== 8'hFA) begin
            errors++;
            $display("FAIL single_rdata lat%0d: rdata0=%h, required fa", lat_of(i), d_rd0[i]);
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int ngr = 0, first_g = 0, last_g = 0;
    int nrv0 [3] = '{0, 0, 0};
    int nrv1 [3] = '{0, 0, 0};
    bit exp0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (4) begin q0.push_back(8'h00); q1.push_back(8'hFF); end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (d_gnt0[0] || d_gnt1[0]) begin
        exp0 = (ngr % 2 == 0);
        checks++;
        if (d_gnt0[0] !== exp0 || d_gnt1[0] !== !exp0 || d_raddr[0] !== (exp0 ? 8'h00 : 8'hFF)) begin
          errors++;
          $display("FAIL rr_grant #%0d: gnt0=%b gnt1=%b raddr=%h, required %b %b %h",
                   ngr, d_gnt0[0], d_gnt1[0], d_raddr[0], exp0, !exp0, exp0 ? 8'h00 : 8'hFF);
        end
        if (ngr == 0) first_g = cyc;
        last_g = cyc;
        ngr++;
      end
      for (int i = 0; i < 3; i++) begin
        if (d_rv0[i]) begin
          nrv0[i]++;
          checks++;
          if (d_rd0[i] !== 8'hFF || d_rv1[i] !== 1'b0) begin
            errors++;
            $display("FAIL rr_rdata0 lat%0d: rdata0=%h rvalid1=%b, required ff 0", lat_of(i), d_rd0[i], d_rv1[i]);
          end
        end
        if (d_rv1[i]) begin
          nrv1[i]++;
          checks++;
          if (d_rd1[i] !== 8'h00) begin
            errors++;
            $display("FAIL rr_rdata1 lat%0d: rdata1=%h, required 00", lat_of(i), d_rd1[i]);
          end
        end
      end
    end
    checks++;
    if (ngr != 8 || last_g - first_g != 7) begin
      errors++;
      $display("FAIL rr_grant_count: %0d grants over %0d cycles, required 8 over 7", ngr, last_g - first_g);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (nrv0[i] != 4 || nrv1[i] != 4) begin
        errors++;
        $display("FAIL rr_rvalid_count lat%0d: %0d/%0d, required 4/4", lat_of(i), nrv0[i], nrv1[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0 = -1, ng = 0;
    int nrv1 [3] = '{0, 0, 0};
    logic [7:0] exp_d;
    q1.push_back(8'h01); q1.push_back(8'h02); q1.push_back(8'h03);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk); #1;
      if (c0 < 0 && req1) c0 = cyc;
      if (d_gnt0[0] || d_gnt1[0]) begin
        checks++;
        if (d_gnt1[0] !== 1'b1 || cyc != c0 + 1 + 2 * ng) begin
          errors++;
          $display("FAIL b2b_grant #%0d: gnt1=%b at req+%0d, required 1 at req+%0d",
                   ng, d_gnt1[0], cyc - c0, 1 + 2 * ng);
        end
        ng++;
      end
      for (int i = 0; i < 3; i++) begin
        if (d_rv1[i] || d_rv0[i]) begin
          exp_d = ~8'(nrv1[i] + 1);
          checks++;
          if (d_rv0[i] !== 1'b0 || d_rd1[i] !== exp_d) begin
            errors++;
            $display("FAIL b2b_rdata lat%0d #%0d: rvalid0=%b rdata1=%h, required 0 %h",
                     lat_of(i), nrv1[i], d_rv0[i], d_rd1[i], exp_d);
          end
          nrv1[i]++;
        end
      end
    end
    checks++;
    if (ng != 3) begin
      errors++;
      $display("FAIL b2b_grant_count: %0d, required 3", ng);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (nrv1[i] != 3) begin
        errors++;
        $display("FAIL b2b_rvalid_count lat%0d: %0d, required 3", lat_of(i), nrv1[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    q0.push_back(8'h10);
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk); #1;
      if (m_gnt0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midflight_wait: no grant for port 0 within 6 cycles");
    end
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_rden[i] !== 1'b0 || d_raddr[i] !== 8'h00) begin
        errors++;
        $display("FAIL midflight_rom lat%0d: rden=%b raddr=%h, required 0 00", lat_of(i), d_rden[i], d_raddr[i]);
      end
    end
    repeat (8) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_rv0[i] !== 1'b0 || d_rd0[i] !== 8'h00) begin
          errors++;
          $display("FAIL midflight_rvalid lat%0d: rvalid0=%b rdata0=%h, required 0 00", lat_of(i), d_rv0[i], d_rd0[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    allow_drop = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_gnt0[i] !== m_gnt0 || d_gnt1[i] !== m_gnt1) begin
          errors++;
          $display("FAIL rand_gnt lat%0d cyc %0d: gnt=%b%b, required %b%b", lat_of(i), cyc, d_gnt0[i], d_gnt1[i], m_gnt0, m_gnt1);
        end
        checks++;
        if (d_rden[i] !== m_rden || d_raddr[i] !== m_addr) begin
          errors++;
          $display("FAIL rand_rom lat%0d cyc %0d: rden=%b raddr=%h, required %b %h", lat_of(i), cyc, d_rden[i], d_raddr[i], m_rden, m_addr);
        end
        checks++;
        if (d_rv0[i] !== m_rv0[i] || d_rd0[i] !== m_rd0[i]) begin
          errors++;
          $display("FAIL rand_port0 lat%0d cyc %0d: rvalid0=%b rdata0=%h, required %b %h", lat_of(i), cyc, d_rv0[i], d_rd0[i], m_rv0[i], m_rd0[i]);
        end
        checks++;
        if (d_rv1[i] !== m_rv1[i] || d_rd1[i] !== m_rd1[i]) begin
          errors++;
          $display("FAIL rand_port1 lat%0d cyc %0d: rvalid1=%b rdata1=%h, required %b %h", lat_of(i), cyc, d_rv1[i], d_rd1[i], m_rv1[i], m_rd1[i]);
        end
      end
      if (rst) rst = 1'b0;
      else if (n < 300 && $urandom_range(63) == 0) rst = 1'b1;
      if (n < 300) begin
        if (q0.size() < 3 && $urandom_range(3) == 0) q0.push_back(8'($urandom));
        if (q1.size() < 3 && $urandom_range(3) == 0) q1.push_back(8'($urandom));
      end else begin
        allow_drop = 1'b0;
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d/%0d requests never granted, required 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = 8'h00;
    addr1 = 8'h00;
    test_reset();
    idle(10);
    test_single_read();
    idle(4);
    test_round_robin();
    idle(4);
    test_back_to_back();
    idle(4);
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
